// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the NPC pipeline
//
// Takes retiring instructions from MEM over a valid/ready handshake and drives
// the single write port of the register file. For a load, the stage waits for
// the data-memory response. It then picks the addressed byte/half/word lane and
// sign- or zero-extends it before committing. The commit cycle also feeds a
// forwarding view and a one-cycle retire pulse for difftest. While a load is
// outstanding, decode sees load_pending/load_rd so it can stall on a hazard.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   in_valid / in_ready            handshake from MEM
//   in_pc, in_rd, in_rd_wen        PC, destination register, rd write enable
//   in_is_load, in_load_size,
//   in_load_signed, in_addr_lo     load descriptor (size 0=B 1=H 2=W 3=D)
//   in_result                      ALU/CSR result for non-loads
//   mem_rvalid, mem_rdata          load response (single-cycle pulse)
//   rf_wen, rf_waddr, rf_wdata     register file write port
//   fwd_valid, fwd_rd, fwd_data    value being written this cycle
//   load_pending, load_rd          outstanding load and its destination
//   retire_valid, retire_pc        one-cycle pulse per committed instruction
//
// Only DATA_WIDTH = 64 is supported: load extraction works on 8 byte lanes.
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int PC_WIDTH   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [1:0]            in_load_size,
    input  logic                  in_load_signed,
    input  logic [2:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_result,

    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data,

    output logic                  load_pending,
    output logic [ADDR_WIDTH-1:0] load_rd,

    output logic                  retire_valid,
    output logic [PC_WIDTH-1:0]   retire_pc
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Select the addressed lane of the aligned 64-bit memory word and extend it.
    // Low address bits below the access size are simply dropped.
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic                  sgn,
        input logic [2:0]            lo
    );
        logic [5:0]            shamt;
        logic [DATA_WIDTH-1:0] lane;
        logic [DATA_WIDTH-1:0] res;
        case (size)
            SZ_BYTE: shamt = {lo, 3'b000};
            SZ_HALF: shamt = {lo[2:1], 4'b0000};
            SZ_WORD: shamt = {lo[2], 5'b00000};
            default: shamt = 6'd0;
        endcase
        lane = word >> shamt;
        case (size)
            SZ_BYTE: res = {{56{sgn & lane[7]}},  lane[7:0]};
            SZ_HALF: res = {{48{sgn & lane[15]}}, lane[15:0]};
            SZ_WORD: res = {{32{sgn & lane[31]}}, lane[31:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    // Packet registers
    state_t                state_q,   state_d;
    logic [PC_WIDTH-1:0]   pc_q,      pc_d;
    logic [ADDR_WIDTH-1:0] rd_q,      rd_d;
    logic                  rd_wen_q,  rd_wen_d;
    logic [1:0]            size_q,    size_d;
    logic                  signed_q,  signed_d;
    logic [2:0]            addr_lo_q, addr_lo_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;

    // Registered outputs
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  load_pending_q;
    logic [ADDR_WIDTH-1:0] load_rd_q;
    logic                  retire_valid_q;
    logic [PC_WIDTH-1:0]   retire_pc_q;

    logic commit_d;
    logic wait_d;

    // Acceptance depends on state only; COMMIT accepts so non-loads stream.
    assign in_ready = (state_q != LOAD_WAIT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        size_d    = size_q;
        signed_d  = signed_q;
        addr_lo_d = addr_lo_q;
        data_d    = data_q;
        case (state_q)
            IDLE, COMMIT: begin
                if (in_valid) begin
                    pc_d      = in_pc;
                    rd_d      = in_rd;
                    rd_wen_d  = in_rd_wen;
                    size_d    = in_load_size;
                    signed_d  = in_load_signed;
                    addr_lo_d = in_addr_lo;
                    if (in_is_load) begin
                        state_d = LOAD_WAIT;
                    end else begin
                        data_d  = in_result;
                        state_d = COMMIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    data_d  = extract(mem_rdata, size_q, signed_q, addr_lo_q);
                    state_d = COMMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit_d = (state_d == COMMIT);
    assign wait_d   = (state_d == LOAD_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            size_q         <= 2'd0;
            signed_q       <= 1'b0;
            addr_lo_q      <= 3'd0;
            data_q         <= '0;
            wen_q          <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            load_pending_q <= 1'b0;
            load_rd_q      <= '0;
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            rd_wen_q       <= rd_wen_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            addr_lo_q      <= addr_lo_d;
            data_q         <= data_d;
            // Outputs are computed from next state so they line up with the
            // cycle the FSM sits in; they read as zero outside their state.
            wen_q          <= commit_d && rd_wen_d && (rd_d != '0);
            waddr_q        <= commit_d ? rd_d : '0;
            wdata_q        <= commit_d ? data_d : '0;
            load_pending_q <= wait_d;
            load_rd_q      <= wait_d ? rd_d : '0;
            retire_valid_q <= commit_d;
            retire_pc_q    <= commit_d ? pc_d : '0;
        end
    end

    assign rf_wen       = wen_q;
    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign fwd_valid    = wen_q;
    assign fwd_rd       = waddr_q;
    assign fwd_data     = wdata_q;
    assign load_pending = load_pending_q;
    assign load_rd      = load_rd_q;
    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the NPC pipeline; sits directly upstream of the register file and drives its single write port (wen/waddr/wdata).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the data before committing.
- Publishes a forwarding/stall view to decode, and a one-cycle retire pulse with the PC for difftest.

Parameters:
- ADDR_WIDTH, 5, register index width; must match the register file.
- DATA_WIDTH, 64, datapath width; only 64 is supported because load extraction is byte-lane based.
- PC_WIDTH, 64, width of the retired PC.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low.
- in_valid  in  1  MEM stage offers a packet.
- in_ready  out  1  stage can accept a packet this cycle.
- in_pc  in  PC_WIDTH  PC of the instruction.
- in_rd  in  ADDR_WIDTH  destination register.
- in_rd_wen  in  1  instruction writes rd.
- in_is_load  in  1  result comes from memory.
- in_load_size  in  2  0=byte, 1=half, 2=word, 3=double.
- in_load_signed  in  1  1 = sign-extend, 0 = zero-extend.
- in_addr_lo  in  3  low three bits of the load address.
- in_result  in  DATA_WIDTH  ALU/CSR result for non-loads.
- mem_rvalid  in  1  load response valid, single-cycle pulse.
- mem_rdata  in  DATA_WIDTH  raw 8-byte-aligned memory word.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wdata  out  DATA_WIDTH  register file write data.
- fwd_valid  out  1  fwd_rd/fwd_data hold a value being written this cycle.
- fwd_rd  out  ADDR_WIDTH  forwarded register index.
- fwd_data  out  DATA_WIDTH  forwarded value.
- load_pending  out  1  a load to load_rd is outstanding; decode must stall on a match.
- load_rd  out  ADDR_WIDTH  destination register of the outstanding load.
- retire_valid  out  1  one-cycle pulse per committed instruction.
- retire_pc  out  PC_WIDTH  PC of the committed instruction.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all packet registers are cleared to 0.
  - All outputs are 0 except in_ready, which is 1.
  - A load in flight is dropped, and its later mem_rvalid is ignored.
- State IDLE: in_ready=1.
  - in_valid && in_is_load: latch packet, go to LOAD_WAIT.
  - in_valid && !in_is_load: latch packet with data=in_result, go to COMMIT.
  - No in_valid: stay in IDLE.
- State LOAD_WAIT: in_ready=0; load_pending=1; load_rd = latched rd.
  - On mem_rvalid: data = extract(mem_rdata), go to COMMIT.
  - No timeout; the stage waits indefinitely.
- State COMMIT: retire_valid=1; retire_pc = latched pc.
  - rf_wen = fwd_valid = (rd_wen && rd!=0); rf_waddr = fwd_rd = rd; rf_wdata = fwd_data = data.
  - in_ready=1, so a new packet accepted in this cycle follows the IDLE transitions. Back-to-back non-loads sustain 1 commit per cycle.
  - No in_valid: go to IDLE.
- Latency:
  - Non-load: commit in the cycle after acceptance.
  - Load: commit in the cycle after the mem_rvalid cycle.
- All outputs are driven from registered state (no combinational in-to-out path), except in_ready, which depends only on state.
- Writes to x0 never assert rf_wen or fwd_valid; retire_valid still pulses.
- mem_rvalid outside LOAD_WAIT is ignored; no state change.
- Load extraction:
  - byte: lane in_addr_lo.
  - half: lane in_addr_lo[2:1].
  - word: lane in_addr_lo[2].
  - double: full word; in_addr_lo ignored.
  - Misaligned low bits below the access size are dropped (no exception raised here).
  - Extension fills bits up to 63 with the lane MSB if in_load_signed, else with 0. in_load_signed is ignored for double.

Test Plan:
- Reset, then non-load {pc=0x80000000, rd=5, result=0x1234}: next cycle rf_wen=1, waddr=5, wdata=0x1234, retire_pc=0x80000000, fwd_valid=1; following cycle all 0.
- Three back-to-back non-loads to rd=1,2,3 with in_valid held high: in_ready stays 1; three consecutive rf_wen cycles in order 1,2,3.
- LB signed, addr_lo=3, rd=7, mem_rvalid 4 cycles later with rdata=0x00000000_80FF0000: in_ready=0 and load_pending=1 with load_rd=7 while waiting; wdata=0xFFFFFFFF_FFFFFF80. Same with LHU, addr_lo=2: wdata=0x80FF.
- Non-load with rd=0, result=0xDEAD: rf_wen=0, fwd_valid=0, retire_valid=1.
- Load accepted, rst_n pulsed low for 1 cycle mid-wait, then mem_rvalid arrives: no rf_wen, no retire_valid; state IDLE; in_ready=1.
- Stray mem_rvalid in IDLE: no outputs change. LWU with addr_lo=4, rdata=0xCAFEBABE_00000000: wdata=0x00000000_CAFEBABE.
